// File: rtl/reg_bank_param.sv
// ---------------------------------------------------------------------------
// reg_bank_param
//   Parametrised register bank between decode and ALU: one synchronous write
//   port and two asynchronous read ports. A clear sequencer sweeps CLR_VAL
//   into every entry after reset and on clr_req. `ready` reports when the bank
//   is usable.
//
//   Parameters
//     DATA_W   word width in bits
//     ADDR_W   address width, DEPTH = 2**ADDR_W entries
//     ZERO_REG 1: entry 0 reads 0 and ignores writes
//     CLR_VAL  value written by the clear sweep
//
//   Ports
//     clk, rst_n            clock (rising edge), async active-low reset
//     clr_req               one-cycle request to re-run the clear sweep
//     adrsReadA/adrsReadB   read addresses, readA/readB combinational data
//     adrsWrite/RegEn/write write address, enable, data
//     ready                 1 = bank usable, 0 = sweep in progress
//     wr_drop               registered pulse: a write was discarded (ready=0)
//
//   Optional feature macro: REGBANK_BYPASS_EN
//     When defined, a RUN-state read of the address being written this cycle
//     returns `write` combinationally (not for entry 0 when ZERO_REG=1).
// ---------------------------------------------------------------------------
module reg_bank_param #(
   parameter int                 DATA_W   = 32,
   parameter int                 ADDR_W   = 5,
   parameter int                 ZERO_REG = 1,
   parameter logic [DATA_W-1:0]  CLR_VAL  = '0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clr_req,
   input  logic [ADDR_W-1:0] adrsReadA,
   input  logic [ADDR_W-1:0] adrsReadB,
   input  logic [ADDR_W-1:0] adrsWrite,
   input  logic              RegEn,
   input  logic [DATA_W-1:0] write,
   output logic [DATA_W-1:0] readA,
   output logic [DATA_W-1:0] readB,
   output logic              ready,
   output logic              wr_drop
);

   localparam int DEPTH = 1 << ADDR_W;
   localparam logic [ADDR_W-1:0] LAST_PTR = {ADDR_W{1'b1}};
   localparam logic ZERO_EN = (ZERO_REG != 0);

   typedef enum logic [0:0] {
      CLEAR = 1'b0,
      RUN   = 1'b1
   } state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] clr_ptr_q, clr_ptr_d;
   logic              ready_q, ready_d;
   logic              wr_drop_q, wr_drop_d;

   logic              mem_we;
   logic [ADDR_W-1:0] mem_wa;
   logic [DATA_W-1:0] mem_wd;

   logic [DATA_W-1:0] mem [DEPTH];

   // Next-state logic: sweep sequencing, write-port steering, drop detection.
   always_comb begin
      state_d   = state_q;
      clr_ptr_d = clr_ptr_q;
      ready_d   = ready_q;
      wr_drop_d = 1'b0;
      mem_we    = 1'b0;
      mem_wa    = adrsWrite;
      mem_wd    = write;
      case (state_q)
         CLEAR: begin
            // The sweep owns the write port; user writes are discarded and
            // flagged, clr_req is ignored so the sweep never restarts.
            mem_we    = 1'b1;
            mem_wa    = clr_ptr_q;
            mem_wd    = CLR_VAL;
            wr_drop_d = RegEn;
            if (clr_ptr_q == LAST_PTR) begin
               state_d   = RUN;
               clr_ptr_d = '0;
               ready_d   = 1'b1;
            end else begin
               clr_ptr_d = clr_ptr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
               ready_d   = 1'b0;
            end
         end
         RUN: begin
            if (RegEn && !(ZERO_EN && (adrsWrite == '0))) begin
               mem_we = 1'b1;
            end else begin
               mem_we = 1'b0;
            end
            // A write on the clr_req edge still lands; the sweep overwrites it.
            if (clr_req) begin
               state_d   = CLEAR;
               clr_ptr_d = '0;
               ready_d   = 1'b0;
            end else begin
               ready_d   = 1'b1;
            end
         end
         default: begin
            state_d   = CLEAR;
            clr_ptr_d = '0;
            ready_d   = 1'b0;
         end
      endcase
   end

   // Control registers with asynchronous reset into the sweep state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= CLEAR;
         clr_ptr_q <= '0;
         ready_q   <= 1'b0;
         wr_drop_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         clr_ptr_q <= clr_ptr_d;
         ready_q   <= ready_d;
         wr_drop_q <= wr_drop_d;
      end
   end

   // Storage array; not reset, the clear sweep initialises it.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem[mem_wa] <= mem_wd;
      end
   end

   // Read port A: zero register, then sweep mask, then optional forward.
   always_comb begin
      readA = mem[adrsReadA];
      if (ZERO_EN && (adrsReadA == '0)) begin
         readA = '0;
      end else if (!ready_q) begin
         readA = CLR_VAL;
`ifdef REGBANK_BYPASS_EN
      end else if (RegEn && (adrsReadA == adrsWrite)) begin
         readA = write;
`endif
      end else begin
         readA = mem[adrsReadA];
      end
   end

   // Read port B: same priority as port A, fully independent.
   always_comb begin
      readB = mem[adrsReadB];
      if (ZERO_EN && (adrsReadB == '0)) begin
         readB = '0;
      end else if (!ready_q) begin
         readB = CLR_VAL;
`ifdef REGBANK_BYPASS_EN
      end else if (RegEn && (adrsReadB == adrsWrite)) begin
         readB = write;
`endif
      end else begin
         readB = mem[adrsReadB];
      end
   end

   assign ready   = ready_q;
   assign wr_drop = wr_drop_q;

endmodule

// File: tb/tb_reg_bank_param.sv
// ---------------------------------------------------------------------------
// tb_reg_bank_param
//   Directed bench for reg_bank_param. Two instances share all inputs:
//   dut (CLR_VAL=0) and dut_ff (CLR_VAL=32'hFFFF_FFFF), both ZERO_REG=1.
// ---------------------------------------------------------------------------
module tb_reg_bank_param;

   logic        clk;
   logic        rst_n;
   logic        clr_req;
   logic [4:0]  adrsReadA;
   logic [4:0]  adrsReadB;
   logic [4:0]  adrsWrite;
   logic        RegEn;
   logic [31:0] write;
   logic [31:0] readA, readB, readA_ff, readB_ff;
   logic        ready, wr_drop, ready_ff, wr_drop_ff;

   int checks   = 0;
   int failures = 0;

`ifdef REGBANK_BYPASS_EN
   localparam logic BYP = 1'b1;
`else
   localparam logic BYP = 1'b0;
`endif

   reg_bank_param #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1), .CLR_VAL(32'h0000_0000)) dut (
      .clk(clk), .rst_n(rst_n), .clr_req(clr_req),
      .adrsReadA(adrsReadA), .adrsReadB(adrsReadB), .adrsWrite(adrsWrite),
      .RegEn(RegEn), .write(write),
      .readA(readA), .readB(readB), .ready(ready), .wr_drop(wr_drop)
   );

   reg_bank_param #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1), .CLR_VAL(32'hFFFF_FFFF)) dut_ff (
      .clk(clk), .rst_n(rst_n), .clr_req(clr_req),
      .adrsReadA(adrsReadA), .adrsReadB(adrsReadB), .adrsWrite(adrsWrite),
      .RegEn(RegEn), .write(write),
      .readA(readA_ff), .readB(readB_ff), .ready(ready_ff), .wr_drop(wr_drop_ff)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n     = 1'b0;
      clr_req   = 1'b0;
      adrsReadA = 5'd3;
      adrsReadB = 5'd0;
      adrsWrite = 5'd0;
      RegEn     = 1'b0;
      write     = 32'h0;
      tick();
      tick();

      // Reset state
      check("rst_ready",      {31'd0, ready},      32'd0);
      check("rst_wr_drop",    {31'd0, wr_drop},    32'd0);
      check("rst_readA",      readA,               32'h0);
      check("rst_ff_readA",   readA_ff,            32'hFFFF_FFFF);
      check("rst_ff_readB0",  readB_ff,            32'h0);

      // 1: sweep after release, ready on the 32nd edge
      rst_n = 1'b1;
      for (int i = 1; i <= 31; i++) begin
         tick();
         check("sweep1_ready", {31'd0, ready}, 32'd0);
      end
      tick();
      check("sweep1_ready_up", {31'd0, ready}, 32'd1);
      for (int i = 0; i < 32; i++) begin
         adrsReadA = 5'(i);
         adrsReadB = 5'(31 - i);
         #1;
         check("sweep1_readA", readA, 32'h0);
         check("sweep1_readB", readB, 32'h0);
      end

      // 2: write r5 and r0
      RegEn = 1'b1; adrsWrite = 5'd5; write = 32'hDEAD_BEEF;
      tick();
      adrsWrite = 5'd0; write = 32'h0000_1234;
      tick();
      RegEn = 1'b0;
      adrsReadA = 5'd5; adrsReadB = 5'd0;
      #1;
      check("wr_r5_readA",   readA,   32'hDEAD_BEEF);
      check("wr_r0_readB",   readB,   32'h0);
      check("wr_r0_ff_readB", readB_ff, 32'h0);
      adrsReadB = 5'd5;
      #1;
      check("same_addr_readB", readB, 32'hDEAD_BEEF);

      // 3: same-cycle write/read of r7
      RegEn = 1'b1; adrsWrite = 5'd7; write = 32'hA5A5_A5A5; adrsReadA = 5'd7;
      #1;
      check("byp_before", readA, BYP ? 32'hA5A5_A5A5 : 32'h0);
      tick();
      RegEn = 1'b0;
      #1;
      check("byp_after", readA, 32'hA5A5_A5A5);
      // Zero register never forwards
      RegEn = 1'b1; adrsWrite = 5'd0; write = 32'h0000_0077; adrsReadB = 5'd0;
      #1;
      check("zero_no_fwd", readB, 32'h0);
      RegEn = 1'b0;

      // 4 + 5: clear request, dropped write during sweep, clr_req ignored mid-sweep
      RegEn = 1'b1; adrsWrite = 5'd9; write = 32'h0000_0099;
      tick();
      RegEn = 1'b0;
      adrsReadA = 5'd9;
      #1;
      check("r9_prefill", readA, 32'h0000_0099);
      clr_req = 1'b1;
      tick();
      clr_req = 1'b0;
      adrsReadA = 5'd5;
      #1;
      check("clr_ready_low", {31'd0, ready}, 32'd0);
      check("clr_readA_mask", readA, 32'h0);
      check("clr_ff_readA_mask", readA_ff, 32'hFFFF_FFFF);
      for (int i = 1; i <= 31; i++) begin
         RegEn     = (i == 5);
         adrsWrite = 5'd9;
         write     = 32'h0000_0055;
         clr_req   = (i == 10);
         tick();
         check("clr_ready", {31'd0, ready}, 32'd0);
         check("clr_wr_drop", {31'd0, wr_drop}, (i == 5) ? 32'd1 : 32'd0);
      end
      RegEn = 1'b0; clr_req = 1'b0;
      tick();
      check("clr_ready_up", {31'd0, ready}, 32'd1);
      check("clr_wr_drop_end", {31'd0, wr_drop}, 32'd0);
      adrsReadA = 5'd5; adrsReadB = 5'd9;
      #1;
      check("clr_r5", readA, 32'h0);
      check("clr_r9", readB, 32'h0);

      // 6: reset mid-sweep at clr_ptr=10
      RegEn = 1'b1; adrsWrite = 5'd12; write = 32'h0000_0012;
      tick();
      RegEn = 1'b0;
      clr_req = 1'b1;
      tick();
      clr_req = 1'b0;
      repeat (10) tick();
      rst_n = 1'b0;
      adrsReadA = 5'd12;
      #1;
      check("midrst_ready", {31'd0, ready}, 32'd0);
      check("midrst_ff_ready", {31'd0, ready_ff}, 32'd0);
      check("midrst_ff_readA", readA_ff, 32'hFFFF_FFFF);
      tick();
      tick();
      check("midrst_hold_ready", {31'd0, ready_ff}, 32'd0);
      rst_n = 1'b1;
      for (int i = 1; i <= 31; i++) begin
         tick();
         check("sweep6_ready", {31'd0, ready_ff}, 32'd0);
      end
      tick();
      check("sweep6_ready_up", {31'd0, ready_ff}, 32'd1);
      check("sweep6_ready_up0", {31'd0, ready}, 32'd1);
      for (int i = 0; i < 32; i++) begin
         adrsReadA = 5'(i);
         adrsReadB = 5'(i);
         #1;
         check("sweep6_ff_readA", readA_ff, (i == 0) ? 32'h0 : 32'hFFFF_FFFF);
         check("sweep6_readB", readB, 32'h0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
